intersection_scheduler: RTL and testbench

- Sequences a two-approach intersection (north-south, east-west) and drives the per-approach RED/YELLOW/GREEN enables plus a pedestrian WALK enable.
- Guarantees that at most one approach is non-red and inserts a yellow and an all-red clearance on every handover.
- Extends green while no competing demand exists.
- Serves latched pedestrian requests in an exclusive all-red walk phase between approaches.

---
 rtl/traffic_pkg.sv | 27 ++
 rtl/intersection_scheduler_if.sv | 41 ++++
 rtl/intersection_scheduler_phase_timer.sv | 26 ++
 rtl/intersection_scheduler.sv | 141 ++++++++++++++
 tb/tb_intersection_scheduler.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared types and default timing for the two-approach intersection scheduler.
// Optional TRAFFIC_PREEMPT_EN adds an emergency preempt input (see top).
package traffic_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      CLEAR_NS  = 3'd3,
      EW_GREEN  = 3'd4,
      EW_YELLOW = 3'd5,
      CLEAR_EW  = 3'd6,
      PED_WALK  = 3'd7
   } phase_t;

   typedef enum logic {
      NS = 1'b0,
      EW = 1'b1
   } dir_t;

   localparam int unsigned GREEN_CYC_DEF  = 180000000;
   localparam int unsigned YELLOW_CYC_DEF = 60000000;
   localparam int unsigned ALLRED_CYC_DEF = 25000000;
   localparam int unsigned WALK_CYC_DEF   = 100000000;
   localparam int unsigned CNT_W_DEF      = 32;

endpackage

// File: rtl/intersection_scheduler_if.sv
// Demand inputs and lamp outputs of the intersection scheduler.
// TRAFFIC_PREEMPT_EN adds the Preempt input.
interface intersection_scheduler_if;
   import traffic_pkg::*;

   logic   Enable;
   logic   Req_NS;
   logic   Req_EW;
   logic   Ped_Req;
`ifdef TRAFFIC_PREEMPT_EN
   logic   Preempt;
`endif
   logic   Ped_Ack;
   logic   NS_RED_EN;
   logic   NS_YELLOW_EN;
   logic   NS_GREEN_EN;
   logic   EW_RED_EN;
   logic   EW_YELLOW_EN;
   logic   EW_GREEN_EN;
   logic   WALK_EN;
   phase_t Phase;

   modport master (
`ifdef TRAFFIC_PREEMPT_EN
      output Preempt,
`endif
      output Enable, Req_NS, Req_EW, Ped_Req,
      input  Ped_Ack, NS_RED_EN, NS_YELLOW_EN, NS_GREEN_EN,
      input  EW_RED_EN, EW_YELLOW_EN, EW_GREEN_EN, WALK_EN, Phase
   );

   modport slave (
`ifdef TRAFFIC_PREEMPT_EN
      input  Preempt,
`endif
      input  Enable, Req_NS, Req_EW, Ped_Req,
      output Ped_Ack, NS_RED_EN, NS_YELLOW_EN, NS_GREEN_EN,
      output EW_RED_EN, EW_YELLOW_EN, EW_GREEN_EN, WALK_EN, Phase
   );

endinterface

// File: rtl/intersection_scheduler_phase_timer.sv
// Phase duration counter: clears on phase change, saturates at the terminal
// value so an extended green keeps reporting done.
module phase_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [CNT_W-1:0] term,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (cnt < term)
         cnt <= cnt + 1'b1;
   end

   assign done = (cnt >= term);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection sequencer with yellow/all-red clearance and
// exclusive pedestrian walk. TRAFFIC_PREEMPT_EN enables north-south preemption.
module intersection_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned GREEN_CYC  = GREEN_CYC_DEF,
   parameter int unsigned YELLOW_CYC = YELLOW_CYC_DEF,
   parameter int unsigned ALLRED_CYC = ALLRED_CYC_DEF,
   parameter int unsigned WALK_CYC   = WALK_CYC_DEF,
   parameter int          CNT_W      = CNT_W_DEF
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   intersection_scheduler_if.slave  bus
);

   phase_t           state, state_n;
   dir_t             next_dir, next_dir_n;
   logic             ped_pending;
   logic             ack_q;
   logic             preempt;
   logic             done;
   logic             clr;
   logic [CNT_W-1:0] term;

`ifdef TRAFFIC_PREEMPT_EN
   assign preempt = bus.Preempt;
`else
   assign preempt = 1'b0;
`endif

   always_comb begin
      term = '0;
      unique case (state)
         NS_GREEN,  EW_GREEN:  term = CNT_W'(GREEN_CYC - 1);
         NS_YELLOW, EW_YELLOW: term = CNT_W'(YELLOW_CYC - 1);
         CLEAR_NS,  CLEAR_EW:  term = CNT_W'(ALLRED_CYC - 1);
         PED_WALK:             term = CNT_W'(WALK_CYC - 1);
         default:              term = '0;
      endcase
   end

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk   (Clk),
      .rst_n (Reset_n),
      .clr   (clr),
      .term  (term),
      .done  (done)
   );

   assign clr = (state_n != state);

   always_comb begin
      state_n    = state;
      next_dir_n = next_dir;
      unique case (state)
         IDLE: begin
            if (bus.Enable)
               state_n = (next_dir == NS) ? NS_GREEN : EW_GREEN;
         end
         NS_GREEN: begin
            if (!preempt && done && (bus.Req_EW || ped_pending))
               state_n = NS_YELLOW;
         end
         NS_YELLOW: begin
            if (done)
               state_n = CLEAR_NS;
         end
         CLEAR_NS: begin
            if (done) begin
               next_dir_n = EW;
               if (!bus.Enable)
                  state_n = IDLE;
               else if (ped_pending)
                  state_n = PED_WALK;
               else
                  state_n = EW_GREEN;
            end
         end
         EW_GREEN: begin
            if (preempt || (done && (bus.Req_NS || ped_pending)))
               state_n = EW_YELLOW;
         end
         EW_YELLOW: begin
            if (done)
               state_n = CLEAR_EW;
         end
         CLEAR_EW: begin
            if (done) begin
               next_dir_n = NS;
               if (preempt)
                  state_n = NS_GREEN;
               else if (!bus.Enable)
                  state_n = IDLE;
               else if (ped_pending)
                  state_n = PED_WALK;
               else
                  state_n = NS_GREEN;
            end
         end
         PED_WALK: begin
            if (done) begin
               if (!bus.Enable)
                  state_n = IDLE;
               else
                  state_n = (next_dir == NS) ? NS_GREEN : EW_GREEN;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // The request is retired during the first walk cycle, so a press in that
   // same cycle is absorbed by the walk already being served.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state       <= IDLE;
         next_dir    <= NS;
         ped_pending <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         state       <= state_n;
         next_dir    <= next_dir_n;
         ped_pending <= (ped_pending | bus.Ped_Req) & ~ack_q;
         ack_q       <= (state_n == PED_WALK) && (state != PED_WALK);
      end
   end

   assign bus.Ped_Ack      = ack_q;
   assign bus.Phase        = state;
   assign bus.NS_GREEN_EN  = (state == NS_GREEN);
   assign bus.NS_YELLOW_EN = (state == NS_YELLOW);
   assign bus.NS_RED_EN    = !(state inside {NS_GREEN, NS_YELLOW});
   assign bus.EW_GREEN_EN  = (state == EW_GREEN);
   assign bus.EW_YELLOW_EN = (state == EW_YELLOW);
   assign bus.EW_RED_EN    = !(state inside {EW_GREEN, EW_YELLOW});
   assign bus.WALK_EN      = (state == PED_WALK);

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed vector bench for intersection_scheduler with short phase timing.
// Preempt is held low when TRAFFIC_PREEMPT_EN is defined.
module tb_intersection_scheduler;
   import traffic_pkg::*;

   typedef struct {
      logic   rst_n;
      logic   en;
      logic   rns;
      logic   rew;
      logic   ped;
      int     n;
      phase_t ph;
      logic   ack;
   } vec_t;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   int   passed = 0;
   int   total = 0;
   vec_t tbl[$];

   always #5 Clk = ~Clk;

   intersection_scheduler_if bus();

   intersection_scheduler #(
      .GREEN_CYC  (8),
      .YELLOW_CYC (3),
      .ALLRED_CYC (2),
      .WALK_CYC   (5),
      .CNT_W      (8)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
   function automatic logic [6:0] lamps(phase_t p);
      case (p)
         NS_GREEN:  return 7'b001_100_0;
         NS_YELLOW: return 7'b010_100_0;
         EW_GREEN:  return 7'b100_001_0;
         EW_YELLOW: return 7'b100_010_0;
         PED_WALK:  return 7'b100_100_1;
         default:   return 7'b100_100_0;
      endcase
   endfunction

   function automatic logic [10:0] observed();
      return {bus.Phase,
              bus.NS_RED_EN, bus.NS_YELLOW_EN, bus.NS_GREEN_EN,
              bus.EW_RED_EN, bus.EW_YELLOW_EN, bus.EW_GREEN_EN,
              bus.WALK_EN, bus.Ped_Ack};
   endfunction

   task automatic chk(string nm, logic [10:0] act, logic [10:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %b want %b", nm, act, exp);
   endtask

   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic add(logic r, logic e, logic ns, logic ew, logic p,
                      int n, phase_t ph, logic a);
      vec_t v;
      v.rst_n = r; v.en = e; v.rns = ns; v.rew = ew; v.ped = p;
      v.n = n; v.ph = ph; v.ack = a;
      tbl.push_back(v);
   endtask

   initial begin
      int k;
      bus.Enable  = 1'b1;
      bus.Req_NS  = 1'b0;
      bus.Req_EW  = 1'b0;
      bus.Ped_Req = 1'b0;
`ifdef TRAFFIC_PREEMPT_EN
      bus.Preempt = 1'b0;
`endif
      //  rst en  ns  ew  ped  n   phase      ack
      add(0, 1, 0, 0, 0,  2, IDLE,      0);
      add(1, 1, 0, 0, 0,  1, NS_GREEN,  0);
      add(1, 1, 0, 0, 0, 30, NS_GREEN,  0);
      add(1, 1, 0, 1, 0,  3, NS_YELLOW, 0);
      add(1, 1, 0, 1, 0,  2, CLEAR_NS,  0);
      add(1, 1, 0, 0, 0,  1, EW_GREEN,  0);
      add(1, 1, 0, 0, 1,  1, EW_GREEN,  0);
      add(1, 1, 0, 0, 0,  6, EW_GREEN,  0);
      add(1, 1, 0, 0, 0,  3, EW_YELLOW, 0);
      add(1, 1, 0, 0, 0,  2, CLEAR_EW,  0);
      add(1, 1, 0, 0, 0,  1, PED_WALK,  1);
      add(1, 1, 0, 0, 1,  1, PED_WALK,  0);
      add(1, 1, 0, 0, 0,  3, PED_WALK,  0);
      add(1, 1, 0, 0, 0,  1, NS_GREEN,  0);
      add(1, 1, 0, 0, 0, 11, NS_GREEN,  0);
      add(1, 1, 0, 1, 0,  1, NS_YELLOW, 0);
      add(1, 1, 0, 1, 1,  1, NS_YELLOW, 0);
      add(0, 1, 0, 1, 0,  1, IDLE,      0);
      add(1, 1, 0, 0, 0,  1, NS_GREEN,  0);
      add(1, 1, 0, 0, 0,  9, NS_GREEN,  0);
      add(1, 1, 0, 1, 0,  3, NS_YELLOW, 0);
      add(1, 1, 0, 0, 0,  2, CLEAR_NS,  0);
      add(1, 1, 0, 0, 0,  1, EW_GREEN,  0);
      add(1, 0, 1, 0, 0,  7, EW_GREEN,  0);
      add(1, 0, 1, 0, 0,  3, EW_YELLOW, 0);
      add(1, 0, 1, 0, 0,  2, CLEAR_EW,  0);
      add(1, 0, 1, 0, 0,  3, IDLE,      0);
      add(1, 1, 1, 0, 0,  1, NS_GREEN,  0);

      foreach (tbl[i]) begin
         Reset_n     = tbl[i].rst_n;
         bus.Enable  = tbl[i].en;
         bus.Req_NS  = tbl[i].rns;
         bus.Req_EW  = tbl[i].rew;
         bus.Ped_Req = tbl[i].ped;
         for (int c = 0; c < tbl[i].n; c++) begin
            step();
            chk($sformatf("vec%0d cyc%0d", i, c), observed(),
                {tbl[i].ph, lamps(tbl[i].ph), tbl[i].ack});
         end
      end

      // Demand present from green entry: handover lands 8+3+2 cycles later.
      bus.Req_NS = 1'b0;
      bus.Req_EW = 1'b1;
      k = 0;
      while (!bus.EW_GREEN_EN && k < 40) begin
         step();
         k++;
         chk($sformatf("overlap k%0d", k),
             {10'd0, !(bus.NS_RED_EN || bus.EW_RED_EN)}, 11'd0);
      end
      chk("handover latency", 11'(k), 11'd13);
      chk("ew green lamps", observed(), {EW_GREEN, lamps(EW_GREEN), 1'b0});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
